// File: rtl/fbc_pkg.sv
// Shared types and the AES S-box table for the wide feedback cipher.
package fbc_pkg;

  typedef enum logic {
    IDLE,
    ACTIVE
  } fbc_state_e;

  typedef enum logic {
    CFB,
    OFB
  } fbc_mode_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/fbc_cipher_wide_if.sv
// Block stream: valid/ready handshake carrying one data block and its last flag.
interface fbc_cipher_wide_if #(
  parameter int unsigned W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] msg;
  logic         last;

  modport master (output valid, output msg, output last, input ready);
  modport slave  (input valid, input msg, input last, output ready);
endinterface

// File: rtl/aes_sbox_byte.sv
// Combinational single-byte AES S-box lookup.
module aes_sbox_byte
  import fbc_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = SBOX[a];
endmodule

// File: rtl/fbc_cipher_wide.sv
// NBYTES-wide CFB/OFB feedback cipher with message framing and a 1-cycle
// registered output stage.
module fbc_cipher_wide
  import fbc_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned W     = 8 * NBYTES
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       key,
  input  logic               new_msg,
  input  logic               enc_dec,
  input  logic               mode,
  fbc_cipher_wide_if.slave   in_bus,
  fbc_cipher_wide_if.master  out_bus,
  output logic               err_seq,
  output logic [CNT_W-1:0]   blk_cnt
);

  fbc_state_e   state;
  fbc_mode_e    mode_q;
  logic         enc_q;
  logic [W-1:0] f_q;

  logic         out_valid_q;
  logic [W-1:0] out_msg_q;
  logic         out_last_q;

  logic         in_ready;
  logic         acc;
  logic         nm_take;
  logic         msg_blk;
  logic         idle_blk;
  fbc_mode_e    mode_eff;
  logic         enc_eff;
  logic [W-1:0] f_eff;
  logic [W-1:0] f_rot;
  logic [W-1:0] ks;
  logic [W-1:0] res;
  logic [W-1:0] f_next;

  assign in_ready = !out_valid_q || out_bus.ready;
  assign acc      = in_bus.valid && in_ready;
  assign nm_take  = new_msg && (!in_bus.valid || in_ready);
  assign msg_blk  = acc && (nm_take || state == ACTIVE);
  assign idle_blk = acc && !nm_take && state == IDLE;

  // A block taken together with new_msg sees the fresh key and settings directly.
  assign f_eff    = nm_take ? key : f_q;
  assign enc_eff  = nm_take ? enc_dec : enc_q;
  assign mode_eff = nm_take ? fbc_mode_e'(mode) : mode_q;

  if (NBYTES == 1) begin : g_rot_id
    assign f_rot = f_eff;
  end else begin : g_rot
    assign f_rot = {f_eff[W-9:0], f_eff[W-1:W-8]};
  end

  for (genvar i = 0; i < NBYTES; i++) begin : g_sbox
    aes_sbox_byte u_sbox (
      .a (f_rot[8*i +: 8]),
      .y (ks[8*i +: 8])
    );
  end

  assign res = in_bus.msg ^ ks;

  always_comb begin
    f_next = ks;
    unique case (mode_eff)
      CFB: f_next = enc_eff ? res : in_bus.msg;
      OFB: f_next = ks;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mode_q      <= CFB;
      enc_q       <= 1'b0;
      f_q         <= '0;
      out_valid_q <= 1'b0;
      out_msg_q   <= '0;
      out_last_q  <= 1'b0;
      err_seq     <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      err_seq <= idle_blk;

      if (nm_take) begin
        state   <= ACTIVE;
        enc_q   <= enc_dec;
        mode_q  <= fbc_mode_e'(mode);
        f_q     <= acc ? f_next : key;
        blk_cnt <= acc ? CNT_W'(1) : '0;
      end else if (msg_blk) begin
        f_q <= f_next;
        if (blk_cnt != '1) blk_cnt <= blk_cnt + 1'b1;
        if (in_bus.last) state <= IDLE;
      end

      if (msg_blk) begin
        out_valid_q <= 1'b1;
        out_msg_q   <= res;
        out_last_q  <= in_bus.last;
      end else if (out_bus.ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_bus.ready  = in_ready;
  assign out_bus.valid = out_valid_q;
  assign out_bus.msg   = out_msg_q;
  assign out_bus.last  = out_last_q;

endmodule

// File: tb/tb_fbc_cipher_wide.sv
// Directed bench for fbc_cipher_wide: byte-wide CFB/OFB vectors, framing,
// reset, and a 4-byte instance under backpressure.
module tb_fbc_cipher_wide;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  key1;
  logic        new_msg1, enc1, mode1, err1;
  logic [15:0] cnt1;
  fbc_cipher_wide_if #(.W(8)) in1();
  fbc_cipher_wide_if #(.W(8)) out1();

  logic [31:0] key4;
  logic        new_msg4, enc4, mode4, err4;
  logic [15:0] cnt4;
  fbc_cipher_wide_if #(.W(32)) in4();
  fbc_cipher_wide_if #(.W(32)) out4();

  fbc_cipher_wide #(.NBYTES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .key(key1), .new_msg(new_msg1), .enc_dec(enc1),
    .mode(mode1), .in_bus(in1), .out_bus(out1), .err_seq(err1), .blk_cnt(cnt1)
  );

  fbc_cipher_wide #(.NBYTES(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .key(key4), .new_msg(new_msg4), .enc_dec(enc4),
    .mode(mode4), .in_bus(in4), .out_bus(out4), .err_seq(err4), .blk_cnt(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic beat1(input logic nm, input logic [7:0] k, input logic ed, input logic md,
                       input logic [7:0] d, input logic last);
    @(negedge clk);
    new_msg1 = nm; key1 = k; enc1 = ed; mode1 = md;
    in1.valid = 1'b1; in1.msg = d; in1.last = last;
    @(posedge clk); #1;
    in1.valid = 1'b0; new_msg1 = 1'b0;
  endtask

  task automatic idle1();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    key1 = '0; new_msg1 = 0; enc1 = 0; mode1 = 0;
    in1.valid = 0; in1.msg = '0; in1.last = 0; out1.ready = 1;
    key4 = '0; new_msg4 = 0; enc4 = 0; mode4 = 0;
    in4.valid = 0; in4.msg = '0; in4.last = 0; out4.ready = 1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out1.valid), 32'h0);
    check("rst_blk_cnt",   32'(cnt1), 32'h0);
    check("rst_in_ready",  32'(in1.ready), 32'h1);
    check("rst_out_msg",   32'(out4.msg), 32'h0);
    @(negedge clk) rst = 1'b1;

    // CFB encrypt, first block carries new_msg
    beat1(1, 8'hA5, 1, 0, 8'h00, 0);
    check("cfb_enc_b0", 32'(out1.msg), 32'h06);
    check("cfb_enc_v0", 32'(out1.valid), 32'h1);
    check("cfb_enc_cnt0", 32'(cnt1), 32'h1);
    beat1(0, 8'h00, 0, 1, 8'h00, 1);
    check("cfb_enc_b1", 32'(out1.msg), 32'h6F);
    check("cfb_enc_last", 32'(out1.last), 32'h1);
    check("cfb_enc_cnt1", 32'(cnt1), 32'h2);
    check("cfb_enc_err", 32'(err1), 32'h0);
    idle1();
    check("drain_valid", 32'(out1.valid), 32'h0);

    // CFB decrypt
    beat1(1, 8'hA5, 0, 0, 8'h06, 0);
    check("cfb_dec_b0", 32'(out1.msg), 32'h00);
    beat1(0, 8'h00, 1, 1, 8'h6F, 1);
    check("cfb_dec_b1", 32'(out1.msg), 32'h00);
    idle1();

    // OFB encrypt; enc/mode wiggled mid-message must be ignored
    beat1(1, 8'h00, 1, 1, 8'h00, 0);
    check("ofb_enc_b0", 32'(out1.msg), 32'h63);
    beat1(0, 8'hFF, 0, 0, 8'h00, 0);
    check("ofb_enc_b1", 32'(out1.msg), 32'hFB);
    beat1(0, 8'hFF, 0, 0, 8'h00, 1);
    check("ofb_enc_b2", 32'(out1.msg), 32'h0F);
    idle1();
    beat1(1, 8'h00, 0, 1, 8'h63, 0);
    check("ofb_dec_b0", 32'(out1.msg), 32'h00);
    beat1(0, 8'h00, 0, 1, 8'hFB, 0);
    check("ofb_dec_b1", 32'(out1.msg), 32'h00);
    beat1(0, 8'h00, 0, 1, 8'h0F, 1);
    check("ofb_dec_b2", 32'(out1.msg), 32'h00);
    idle1();

    // Framing: block outside a message, then a 2-block message, then a stray block
    beat1(0, 8'h00, 1, 0, 8'h55, 0);
    check("frm_idle_err", 32'(err1), 32'h1);
    check("frm_idle_valid", 32'(out1.valid), 32'h0);
    idle1();
    check("frm_err_pulse", 32'(err1), 32'h0);
    beat1(1, 8'hA5, 1, 0, 8'h00, 0);
    check("frm_b1", 32'(out1.msg), 32'h06);
    beat1(0, 8'h00, 1, 0, 8'h00, 1);
    check("frm_b2_last", 32'(out1.last), 32'h1);
    check("frm_b2_msg", 32'(out1.msg), 32'h6F);
    beat1(0, 8'h00, 1, 0, 8'h00, 0);
    check("frm_b3_err", 32'(err1), 32'h1);
    check("frm_b3_valid", 32'(out1.valid), 32'h0);
    check("frm_b3_cnt", 32'(cnt1), 32'h2);

    // Asynchronous reset mid-message
    beat1(1, 8'hA5, 1, 0, 8'h00, 0);
    check("mid_b0", 32'(out1.msg), 32'h06);
    @(negedge clk); rst = 1'b0; #1;
    check("mid_rst_valid", 32'(out1.valid), 32'h0);
    check("mid_rst_cnt",   32'(cnt1), 32'h0);
    check("mid_rst_ready", 32'(in1.ready), 32'h1);
    @(negedge clk); rst = 1'b1;
    beat1(0, 8'h00, 1, 0, 8'h00, 0);
    check("post_rst_err", 32'(err1), 32'h1);
    check("post_rst_valid", 32'(out1.valid), 32'h0);

    // 4-byte instance: backpressure, plus a new_msg that must not be taken while stalled
    @(negedge clk);
    out4.ready = 1'b0; new_msg4 = 1; key4 = 32'h0; enc4 = 1; mode4 = 0;
    in4.valid = 1; in4.msg = 32'h0; in4.last = 0;
    @(posedge clk); #1;
    check("bp_b0", out4.msg, 32'h63636363);
    check("bp_cnt0", 32'(cnt4), 32'h1);
    new_msg4 = 0; in4.last = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      new_msg4 = (i == 1);
      key4 = 32'hFFFFFFFF;
      check("bp_stall_ready", 32'(in4.ready), 32'h0);
      @(posedge clk); #1;
      check("bp_stall_msg", out4.msg, 32'h63636363);
      check("bp_stall_cnt", 32'(cnt4), 32'h1);
    end
    @(negedge clk);
    new_msg4 = 0; out4.ready = 1'b1;
    @(posedge clk); #1;
    in4.valid = 0;
    check("bp_b1", out4.msg, 32'hFBFBFBFB);
    check("bp_b1_last", 32'(out4.last), 32'h1);
    check("bp_cnt1", 32'(cnt4), 32'h2);
    @(posedge clk); #1;

    // Byte rotation: key 00010203 rotates to 01020300 before the S-box
    @(negedge clk);
    new_msg4 = 1; key4 = 32'h00010203; enc4 = 1; mode4 = 0;
    in4.valid = 1; in4.msg = 32'h0; in4.last = 1;
    @(posedge clk); #1;
    new_msg4 = 0; in4.valid = 0;
    check("rot_b0", out4.msg, 32'h7c777b63);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fbc_cipher_wide.md
# fbc_cipher_wide

Parametrised successor of the byte-wide feedback cipher. It processes NBYTES-byte blocks per beat, in CFB or OFB mode, for encryption or decryption. It uses valid/ready handshakes on both sides and explicit message framing. A first block presented in the same cycle as new_msg is ciphered with the key as feedback; it is never skipped. It sits between the message source and the link framer.

## Interface
- NBYTES, 4, bytes per block; data width W = 8*NBYTES; NBYTES=1 is bit-compatible with the byte cipher in CFB.
- CNT_W, 16, width of the block counter.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- key  in  W  feedback seed, sampled when new_msg is taken.
- new_msg  in  1  starts a message; latches key, enc_dec and mode.
- enc_dec  in  1  1 = encrypt, 0 = decrypt.
- mode  in  1  0 = CFB, 1 = OFB.
- in_valid  in  1  in_msg/in_last valid.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in_msg  in  W  input block.
- in_last  in  1  final block of the message.
- out_valid  out  1  out_msg valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_msg  out  W  result block.
- out_last  out  1  copy of in_last for this block.
- err_seq  out  1  one-cycle pulse: a block arrived outside a message.
- blk_cnt  out  CNT_W  blocks accepted in the current message; saturates at all-ones.

## Operation
- Keystream KS = bytewise AES S-box of rotl8(F). F is the W-bit feedback register. rotl8 rotates left by one byte and is the identity for NBYTES=1.
- Result out = in_msg ^ KS.
- F update on an accepted block:
  - CFB encrypt: F <= out.
  - CFB decrypt: F <= in_msg.
  - OFB, either direction: F <= KS.
- new_msg is taken when new_msg && (!in_valid || in_ready).
- Taking new_msg does all of the following:
  - Latches enc_dec and mode.
  - Clears blk_cnt.
  - Enters ACTIVE.
  - If a block is accepted in the same cycle, that block is ciphered with F = key. Otherwise F <= key.
- States:
  - IDLE, the reset state.
  - ACTIVE.
- Transitions:
  - IDLE→ACTIVE when new_msg is taken.
  - ACTIVE→IDLE on an accepted block with in_last=1 and no new_msg in that cycle.
  - new_msg while ACTIVE restarts the message. The new key applies.
- A block in IDLE without new_msg is consumed (in_ready=1), produces no output, and pulses err_seq. F is unchanged.
- enc_dec and mode changes mid-message are ignored until the next new_msg.

## Timing
- Reset values:
  - in_ready=1 (comb: !out_valid || out_ready).
  - out_valid=0, out_msg=0, out_last=0, err_seq=0, blk_cnt=0.
  - F=0, state IDLE.
- Latency is 1 cycle: a block accepted at edge k is on out_msg with out_valid=1 after edge k.
- Throughput is 1 block/cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_msg and out_last hold, and in_ready=0.
- Output register reloads in the same cycle it drains (in_ready=1 when out_ready=1).
- in_valid && new_msg with in_ready=0: neither is taken. The key is not loaded.
- Asynchronous reset mid-message: everything returns to reset values immediately. Any pending out_valid is dropped. The next block needs a new_msg.
- blk_cnt increments on each accepted in-message block and stops at 2^CNT_W-1.

## Structure
- Package fbc_pkg:
  - 256-entry S-box constant.
  - Typedef fbc_state_e {IDLE, ACTIVE}.
  - Typedef fbc_mode_e {CFB, OFB}.
- Sub-module aes_sbox_byte: combinational 8-bit S-box lookup, instantiated NBYTES times.
- Top level holds F, the FSM, the counter and the output register.

## Test plan
- Reset:
  - Stimulus: assert rst=0 mid-message.
  - Response: out_valid=0, blk_cnt=0, in_ready=1, no output for following blocks without new_msg.
- CFB encrypt:
  - Stimulus: NBYTES=1, key A5, new_msg and in_valid in the same cycle, plaintext 00, 00.
  - Response: outputs 06, 6F. The first block is not skipped.
- CFB decrypt:
  - Stimulus: NBYTES=1, key A5, ciphertext 06, 6F.
  - Response: outputs 00, 00.
- OFB:
  - Stimulus: NBYTES=1, key 00, mode=1, inputs 00, 00, 00.
  - Response: outputs 63, FB, 0F. Decrypting those outputs returns 00s.
- Backpressure:
  - Stimulus: NBYTES=4, key 00000000, CFB encrypt, two blocks 00000000, out_ready=0 for 3 cycles.
  - Response:
    - out_msg holds 63636363 and in_ready=0 while stalled.
    - The second block is not taken until release, then produces FBFBFBFB.
    - blk_cnt=2.
- Framing:
  - Stimulus: block in IDLE without new_msg, then a message whose block 2 has in_last=1, then block 3 without new_msg.
  - Response:
    - The IDLE block gives an err_seq pulse and no out_valid.
    - Block 2 gives out_last=1 and the FSM returns to IDLE.
    - Block 3 pulses err_seq.
